core0_char_port: RTL and testbench

//  Synthesizable character-stream peer for one core0 UARC bus, the hardware counterpart of the stdio bench.

---
 rtl/core0_pkg.sv | 15 +
 rtl/core0_char_fifo.sv | 71 +++++++
 rtl/core0_char_port.sv | 91 +++++++++
 tb/tb_core0_char_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core0_pkg.sv
// Shared definitions for the core0 character port.
//   char_t       - one 8-bit character as carried on the device link
//   word_width() - core word width derived from its log2 magnitude
package core0_pkg;

  typedef logic [7:0] char_t;

  localparam int CHAR_WIDTH = 8;

  // Core word width is always a power of two, given as log2.
  function automatic int word_width(input int word_mag);
    return 1 << word_mag;
  endfunction

endpackage

// File: rtl/core0_char_fifo.sv
// Small synchronous FIFO used once per direction by core0_char_port.
// Ports:
//   clk, reset     clock (rising edge) and asynchronous active-low reset
//   push/push_data write one entry (ignored while full)
//   pop            remove the head entry (ignored while empty)
//   head           current head entry, read combinationally from storage
//   empty/full     derived from the registered occupancy count
// Pointers are DEPTH_MAG bits and wrap naturally; the count carries one
// extra bit so that "full" and "empty" are distinguishable.
module core0_char_fifo
  import core0_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH_MAG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_MAG;
  localparam logic [DEPTH_MAG:0] FULL_COUNT = {1'b1, {DEPTH_MAG{1'b0}}};

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_MAG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_MAG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_MAG:0]   count_q, count_d;
  logic                 push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign head  = mem_q[rd_ptr_q];

  // Flags are taken from the pre-edge count, so a pop on a full FIFO does
  // not make room for a push on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_MAG'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_MAG'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (DEPTH_MAG + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_MAG + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/core0_char_port.sv
// Character-stream peer for one core0 UARC bus.
// Core sends become output characters (TX); input characters become sends
// toward the core's receiver port (RX). Each direction is buffered by its
// own core0_char_fifo so neither side stalls the other cycle by cycle.
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   sender_enable, global_send,
//   global_data, sender_send_ack        core -> port offer/ack
//   receiver_send, receiver_data,
//   receiver_send_ack                   port -> core offer/ack
//   tx_char_valid, tx_char, tx_char_ready  port -> device characters
//   rx_char_valid, rx_char, rx_char_ready  device -> port characters
// Handshake: a transfer happens on a rising edge where the offering side's
// valid/send and the accepting side's ready/ack are both 1. Offers stay
// stable until accepted; ready/ack never depend on anything registered after
// the edge, and ack toward the core is withheld while reset is asserted.
module core0_char_port
  import core0_pkg::*;
#(
  parameter int WORD_MAG       = 5,
  parameter int FIFO_DEPTH_MAG = 2,
  localparam int WORD_WIDTH    = word_width(WORD_MAG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sender_enable,
  input  logic                  global_send,
  input  logic [WORD_WIDTH-1:0] global_data,
  output logic                  sender_send_ack,
  output logic                  receiver_send,
  output logic [WORD_WIDTH-1:0] receiver_data,
  input  logic                  receiver_send_ack,
  output logic                  tx_char_valid,
  output logic [7:0]            tx_char,
  input  logic                  tx_char_ready,
  input  logic                  rx_char_valid,
  input  logic [7:0]            rx_char,
  output logic                  rx_char_ready
);

  logic  tx_empty, tx_full, tx_pop;
  logic  rx_empty, rx_full, rx_push, rx_pop;
  char_t tx_head, rx_head;

  // Only the low character of a core word travels to the device.
  logic unused_upper;
  assign unused_upper = ^global_data[WORD_WIDTH-1:CHAR_WIDTH];

  // Gating with reset keeps a held core offer from being acked while the
  // FIFOs are being cleared, and keeps rx_char_ready low under reset.
  assign sender_send_ack = sender_enable & global_send & ~tx_full & reset;
  assign rx_char_ready   = ~rx_full & reset;

  assign tx_char_valid = ~tx_empty;
  assign tx_char       = tx_head;
  assign tx_pop        = tx_char_valid & tx_char_ready;

  assign rx_push       = rx_char_valid & rx_char_ready;
  assign receiver_send = ~rx_empty;
  assign receiver_data = {{(WORD_WIDTH - CHAR_WIDTH){1'b0}}, rx_head};
  assign rx_pop        = receiver_send & receiver_send_ack;

  core0_char_fifo #(
    .WIDTH    (CHAR_WIDTH),
    .DEPTH_MAG(FIFO_DEPTH_MAG)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (sender_send_ack),
    .push_data(global_data[CHAR_WIDTH-1:0]),
    .pop      (tx_pop),
    .head     (tx_head),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  core0_char_fifo #(
    .WIDTH    (CHAR_WIDTH),
    .DEPTH_MAG(FIFO_DEPTH_MAG)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_data(rx_char),
    .pop      (rx_pop),
    .head     (rx_head),
    .empty    (rx_empty),
    .full     (rx_full)
  );

endmodule

// File: tb/tb_core0_char_port.sv
// Directed bench for core0_char_port (WORD_MAG=5, FIFO depth 4).
// Inputs change 1 time unit after a rising edge; outputs are checked one
// further time unit later, well away from the next rising edge.
module tb_core0_char_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        sender_enable, global_send;
  logic [31:0] global_data;
  logic        sender_send_ack;
  logic        receiver_send;
  logic [31:0] receiver_data;
  logic        receiver_send_ack;
  logic        tx_char_valid;
  logic [7:0]  tx_char;
  logic        tx_char_ready;
  logic        rx_char_valid;
  logic [7:0]  rx_char;
  logic        rx_char_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] words [5];
  logic [7:0]  exp_q [$];

  core0_char_port #(
    .WORD_MAG      (5),
    .FIFO_DEPTH_MAG(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sender_enable    (sender_enable),
    .global_send      (global_send),
    .global_data      (global_data),
    .sender_send_ack  (sender_send_ack),
    .receiver_send    (receiver_send),
    .receiver_data    (receiver_data),
    .receiver_send_ack(receiver_send_ack),
    .tx_char_valid    (tx_char_valid),
    .tx_char          (tx_char),
    .tx_char_ready    (tx_char_ready),
    .rx_char_valid    (rx_char_valid),
    .rx_char          (rx_char),
    .rx_char_ready    (rx_char_ready)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge (inputs may change there).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  function automatic logic [46:0] all_out();
    return {sender_send_ack, receiver_send, receiver_data, tx_char_valid, tx_char, rx_char_ready};
  endfunction

  initial begin
    reset = 1'b0;
    sender_enable = 1'b0; global_send = 1'b0; global_data = '0;
    receiver_send_ack = 1'b0; tx_char_ready = 1'b0;
    rx_char_valid = 1'b0; rx_char = '0;
    words[0] = 32'hFFFF_FF10; words[1] = 32'h1234_5621; words[2] = 32'hABCD_EF32;
    words[3] = 32'h0000_0143; words[4] = 32'h8000_0054;

    // Reset state.
    repeat (3) step();
    chk("reset_outputs", 32'(all_out() != '0), 32'h0);
    reset = 1'b1;

    // 1: idle after release; only rx_char_ready (RX not full) is high.
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("idle_outputs", 32'(all_out()), 32'h1);
      step();
    end

    // 2: single send, combinational ack, 1-cycle latency to tx_char_valid.
    sender_enable = 1'b1; global_send = 1'b1; global_data = 32'hDEAD_BE41;
    settle();
    chk("t2_ack", 32'(sender_send_ack), 32'h1);
    chk("t2_valid_pre", 32'(tx_char_valid), 32'h0);
    step();
    global_send = 1'b0;
    settle();
    chk("t2_valid", 32'(tx_char_valid), 32'h1);
    chk("t2_char", 32'(tx_char), 32'h41);
    tx_char_ready = 1'b1;
    step();
    tx_char_ready = 1'b0;
    settle();
    chk("t2_drained", 32'(tx_char_valid), 32'h0);

    // 3: five back-to-back offers into a depth-4 FIFO.
    for (int i = 0; i < 4; i++) begin
      global_send = 1'b1; global_data = words[i];
      settle();
      chk("t3_ack_fill", 32'(sender_send_ack), 32'h1);
      exp_q.push_back(words[i][7:0]);
      step();
    end
    global_data = words[4];
    settle();
    chk("t3_ack_full", 32'(sender_send_ack), 32'h0);
    step();
    chk("t3_ack_full_hold", 32'(sender_send_ack), 32'h0);
    tx_char_ready = 1'b1;
    settle();
    // Pop happens this edge but the full flag still blocks the push.
    chk("t3_ack_full_pop", 32'(sender_send_ack), 32'h0);
    chk("t3_head0", 32'(tx_char), 32'(exp_q.pop_front()));
    step();
    chk("t3_ack_after_pop", 32'(sender_send_ack), 32'h1);
    exp_q.push_back(words[4][7:0]);
    chk("t3_head1", 32'(tx_char), 32'(exp_q.pop_front()));
    step();
    global_send = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_valid", 32'(tx_char_valid), 32'h1);
      chk("t3_order", 32'(tx_char), 32'(exp_q.pop_front()));
      step();
    end
    settle();
    chk("t3_empty", 32'(tx_char_valid), 32'h0);
    tx_char_ready = 1'b0;

    // 4: device sends 'h','i'; core sees zero-extended words.
    rx_char_valid = 1'b1; rx_char = 8'h68;
    settle();
    chk("t4_ready", 32'(rx_char_ready), 32'h1);
    chk("t4_send_pre", 32'(receiver_send), 32'h0);
    step();
    rx_char = 8'h69;
    settle();
    chk("t4_send", 32'(receiver_send), 32'h1);
    chk("t4_data_h", receiver_data, 32'h68);
    step();
    rx_char_valid = 1'b0;
    step();
    chk("t4_data_hold", receiver_data, 32'h68);
    receiver_send_ack = 1'b1;
    step();
    chk("t4_data_i", receiver_data, 32'h69);
    chk("t4_send_i", 32'(receiver_send), 32'h1);
    step();
    chk("t4_send_done", 32'(receiver_send), 32'h0);
    // Ack while nothing is offered must be ignored.
    step();
    receiver_send_ack = 1'b0;
    rx_char_valid = 1'b1; rx_char = 8'h5A;
    step();
    rx_char_valid = 1'b0;
    settle();
    chk("t4_after_stray_ack", receiver_data, 32'h5A);
    receiver_send_ack = 1'b1;
    step();
    receiver_send_ack = 1'b0;
    chk("t4_stray_empty", 32'(receiver_send), 32'h0);

    // 5: RX full, push and pop offered on the same edge -> pop only.
    rx_char_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_char = 8'h30 + 8'(i);
      step();
    end
    rx_char = 8'h34; receiver_send_ack = 1'b1;
    settle();
    chk("t5_ready_full", 32'(rx_char_ready), 32'h0);
    chk("t5_head", receiver_data, 32'h30);
    step();
    rx_char_valid = 1'b0; receiver_send_ack = 1'b0;
    settle();
    chk("t5_ready_rise", 32'(rx_char_ready), 32'h1);
    receiver_send_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("t5_order", receiver_data, 32'h30 + 32'(i));
      step();
    end
    chk("t5_no_push", 32'(receiver_send), 32'h0);
    receiver_send_ack = 1'b0;

    // 6: reset with 3 characters buffered each way.
    global_send = 1'b1; rx_char_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      global_data = 32'h61 + 32'(i);
      rx_char = 8'h71 + 8'(i);
      step();
    end
    global_data = 32'hCAFE_007E; rx_char_valid = 1'b0;
    reset = 1'b0;
    settle();
    chk("t6_reset_outputs", 32'(all_out() != '0), 32'h0);
    step();
    chk("t6_reset_hold", 32'(all_out() != '0), 32'h0);
    reset = 1'b1;
    settle();
    chk("t6_ack_after_release", 32'(sender_send_ack), 32'h1);
    chk("t6_rx_clean", 32'(receiver_send), 32'h0);
    step();
    global_send = 1'b0;
    settle();
    chk("t6_tx_fresh", 32'(tx_char), 32'h7E);
    tx_char_ready = 1'b1;
    step();
    tx_char_ready = 1'b0;
    settle();
    chk("t6_no_stale_tx", 32'(tx_char_valid), 32'h0);
    chk("t6_no_stale_rx", 32'(receiver_send), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
